// File: rtl/voice_alloc.sv
// Polyphonic voice allocator. Turns NOTE_ON / NOTE_OFF strobes into per-voice
// note, velocity, gate and retrigger pulse. Allocation priority is:
// same-note retrigger, then lowest free voice, then steal the oldest voice.
//
// Ports:
//   i_clk         system clock
//   i_rst_n       synchronous active-low reset
//   i_note_on     one-cycle NOTE_ON strobe
//   i_note_off    one-cycle NOTE_OFF strobe
//   i_note        MIDI note, valid with a strobe
//   i_velocity    MIDI velocity, valid with a strobe
//   i_all_off     level; clears every gate at each edge it is high
//   o_voice_note  packed per-voice note, voice i at [7i+6:7i]
//   o_voice_vel   packed per-voice velocity, same layout
//   o_voice_gate  gate per voice
//   o_voice_trig  one-cycle retrigger pulse per voice
//   o_steal       one-cycle pulse: last allocation stole a voice
//   o_last_voice  index of the most recently assigned voice
//   o_busy        high while a command is in flight
//   o_dropped     one-cycle pulse: a strobe was ignored
module voice_alloc #(
  parameter int unsigned VOICES = 4,
  parameter int unsigned AGE_W  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_note_on,
  input  logic                  i_note_off,
  input  logic [6:0]            i_note,
  input  logic [6:0]            i_velocity,
  input  logic                  i_all_off,
  output logic [7*VOICES-1:0]   o_voice_note,
  output logic [7*VOICES-1:0]   o_voice_vel,
  output logic [VOICES-1:0]     o_voice_gate,
  output logic [VOICES-1:0]     o_voice_trig,
  output logic                  o_steal,
  output logic [2:0]            o_last_voice,
  output logic                  o_busy,
  output logic                  o_dropped
);

  typedef enum logic [1:0] {StIdle, StCalc, StApply} state_e;
  typedef enum logic [2:0] {ModeNone, ModeRetrig, ModeFree, ModeSteal, ModeRelease} mode_e;

  state_e              r_state, w_state_next;
  mode_e               r_mode;
  logic                r_cmd_on;
  logic [6:0]          r_note;
  logic [6:0]          r_vel;
  logic [2:0]          r_target;
  logic [VOICES-1:0]   r_rel_mask;
  logic [AGE_W-1:0]    r_age [VOICES];
  logic [7*VOICES-1:0] r_voice_note;
  logic [7*VOICES-1:0] r_voice_vel;
  logic [VOICES-1:0]   r_gate;
  logic [VOICES-1:0]   r_trig;
  logic                r_steal;
  logic [2:0]          r_last_voice;
  logic                r_dropped;

  logic                w_strobe;
  logic                w_dropped;
  logic [VOICES-1:0]   w_match;
  logic                w_retrig_hit;
  logic [2:0]          w_retrig_idx;
  logic                w_free_hit;
  logic [2:0]          w_free_idx;
  logic [2:0]          w_old_idx;
  logic [AGE_W-1:0]    w_old_age;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_strobe) w_state_next = StCalc;
      StCalc:  w_state_next = StApply;
      StApply: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy = (r_state != StIdle);
  end

  assign w_strobe = i_note_on | i_note_off;
  // Ignored strobe while busy, or a simultaneous on/off pair where off loses.
  assign w_dropped = ((r_state != StIdle) && w_strobe) ||
                     ((r_state == StIdle) && i_note_on && i_note_off);

  // Target search over the current voice pool. Loops scan downward so the
  // lowest matching index is the one left standing.
  always_comb begin
    w_match      = '0;
    w_retrig_hit = 1'b0;
    w_retrig_idx = '0;
    w_free_hit   = 1'b0;
    w_free_idx   = '0;
    w_old_idx    = '0;
    w_old_age    = r_age[0];
    for (int i = 0; i < VOICES; i++) begin
      w_match[i] = r_gate[i] && (r_voice_note[7*i +: 7] == r_note);
    end
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_retrig_hit = 1'b1;
        w_retrig_idx = 3'(i);
      end
      if (!r_gate[i]) begin
        w_free_hit = 1'b1;
        w_free_idx = 3'(i);
      end
    end
    // Strict compare keeps the lowest index on ties.
    for (int i = 1; i < VOICES; i++) begin
      if (r_age[i] > w_old_age) begin
        w_old_age = r_age[i];
        w_old_idx = 3'(i);
      end
    end
  end

  // Command latch, target calculation and voice register updates
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mode       <= ModeNone;
      r_cmd_on     <= 1'b0;
      r_note       <= '0;
      r_vel        <= '0;
      r_target     <= '0;
      r_rel_mask   <= '0;
      r_voice_note <= '0;
      r_voice_vel  <= '0;
      r_gate       <= '0;
      r_trig       <= '0;
      r_steal      <= 1'b0;
      r_last_voice <= '0;
      r_dropped    <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      r_trig    <= '0;
      r_steal   <= 1'b0;
      r_dropped <= w_dropped;
      unique case (r_state)
        StIdle: begin
          if (w_strobe) begin
            // Zero-velocity note_on is a note_off.
            r_cmd_on <= i_note_on && (i_velocity != 7'd0);
            r_note   <= i_note;
            r_vel    <= i_velocity;
          end
        end
        StCalc: begin
          r_rel_mask <= w_match;
          if (r_cmd_on) begin
            if (w_retrig_hit) begin
              r_mode   <= ModeRetrig;
              r_target <= w_retrig_idx;
            end else if (w_free_hit) begin
              r_mode   <= ModeFree;
              r_target <= w_free_idx;
            end else begin
              r_mode   <= ModeSteal;
              r_target <= w_old_idx;
            end
          end else begin
            r_mode <= (w_match != '0) ? ModeRelease : ModeNone;
          end
        end
        StApply: begin
          if (r_mode == ModeRetrig || r_mode == ModeFree || r_mode == ModeSteal) begin
            for (int i = 0; i < VOICES; i++) begin
              if (3'(i) == r_target) begin
                r_voice_note[7*i +: 7] <= r_note;
                r_voice_vel[7*i +: 7]  <= r_vel;
                r_gate[i]              <= 1'b1;
                r_trig[i]              <= 1'b1;
                r_age[i]               <= '0;
              end else if (r_age[i] != '1) begin
                r_age[i] <= r_age[i] + 1'b1;
              end
            end
            r_last_voice <= r_target;
            r_steal      <= (r_mode == ModeSteal);
          end else if (r_mode == ModeRelease) begin
            r_gate <= r_gate & ~r_rel_mask;
          end
        end
        default: ;
      endcase
      // Last assignment wins over any APPLY gate write above.
      if (i_all_off) begin
        r_gate <= '0;
      end
    end
  end

  assign o_voice_note = r_voice_note;
  assign o_voice_vel  = r_voice_vel;
  assign o_voice_gate = r_gate;
  assign o_voice_trig = r_trig;
  assign o_steal      = r_steal;
  assign o_last_voice = r_last_voice;
  assign o_dropped    = r_dropped;

endmodule
